digiota_diff_driver: RTL

DIGIOTA_DIFF_DRIVER -- requirements
Module: digiota_diff_driver

---
 rtl/digiota_diff_driver.sv | 102 ++++++++++
 1 files changed

// File: rtl/digiota_diff_driver.sv
// rtl/digiota_diff_driver.sv - first-order sigma-delta differential bitstream driver for an OTA input pair
// Optional per-frame ones counter enabled by defining DIGIOTA_ONES_CNT_EN.
module digiota_diff_driver #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] code,
  input  logic          code_valid,
  output logic          code_ready,
  output logic          vip,
  output logic          vin,
  output logic          busy,
  output logic          frame_done,
  output logic [DW:0]   ones_cnt
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state;
  logic [DW-1:0] acc;
  logic [DW-1:0] cnt;
  logic [DW-1:0] u;
  logic [DW:0]   sum;
  logic [DW-1:0] u_new;
  logic          cnt_zero;
  logic          accept;
  logic          carry;

  assign cnt_zero   = (cnt == '0);
  assign code_ready = (state == IDLE) || cnt_zero;
  assign accept     = code_valid && code_ready;
  assign busy       = (state == RUN);
  assign sum        = {1'b0, acc} + {1'b0, u};
  assign carry      = sum[DW];
  // Offset binary: flipping the sign bit maps -2^(DW-1)..2^(DW-1)-1 onto 0..2^DW-1.
  assign u_new      = {~code[DW-1], code[DW-2:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      acc        <= '0;
      cnt        <= '0;
      u          <= '0;
      vip        <= 1'b0;
      vin        <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          vip        <= 1'b0;
          vin        <= 1'b0;
          frame_done <= 1'b0;
          if (accept) begin
            u     <= u_new;
            acc   <= '0;
            cnt   <= '1;
            state <= RUN;
          end
        end
        RUN: begin
          acc        <= sum[DW-1:0];
          vip        <= carry;
          vin        <= ~carry;
          cnt        <= cnt - DW'(1);
          frame_done <= cnt_zero;
          // The last bit of a frame still uses the old u; a new code takes over on the next edge.
          if (cnt_zero) begin
            if (accept) begin
              u   <= u_new;
              cnt <= '1;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DIGIOTA_ONES_CNT_EN
  logic [DW:0] ones_acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      ones_acc <= '0;
      ones_cnt <= '0;
    end else if (state == RUN) begin
      if (cnt_zero) begin
        ones_cnt <= ones_acc + {{DW{1'b0}}, carry};
        ones_acc <= '0;
      end else begin
        ones_acc <= ones_acc + {{DW{1'b0}}, carry};
      end
    end
  end
`else
  assign ones_cnt = '0;
`endif

endmodule
